// File: rtl/axis_pkt_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : axis_pkt_rr_arbiter
//  Description : Packet-level round-robin arbiter sharing one AXI-Stream sink
//                between N_IN sources. A granted source owns the output for
//                exactly N_BEATS handshaken beats; packets carry no tlast.
//                One idle bubble separates consecutive packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_rr_arbiter #(
    parameter int N_IN    = 4,
    parameter int WORD_W  = 8,
    parameter int BUS_W   = 8,
    parameter int N_BEATS = 10,
    localparam int GNT_W  = $clog2(N_IN),
    localparam int CNT_W  = $clog2(N_BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_IN-1:0]         s_valid,
    output logic [N_IN-1:0]         s_ready,
    input  logic [N_IN*BUS_W-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [BUS_W-1:0]        m_data,
    output logic [GNT_W-1:0]        grant,
    output logic                    busy,
    output logic [CNT_W-1:0]        beat_cnt
);

    localparam int WORDS_PER_BEAT = BUS_W / WORD_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t             r_state;
    logic [GNT_W-1:0]   r_grant;
    logic [GNT_W-1:0]   r_last_grant;
    logic               r_busy;
    logic [CNT_W-1:0]   r_beat_cnt;

    logic               w_lock;
    logic               w_any_req;
    logic [GNT_W-1:0]   w_pick;
    logic               w_hs;
    logic               w_last_beat;
    logic               w_m_valid;
    logic [N_IN-1:0]    w_s_ready;
    logic [BUS_W-1:0]   w_m_data;

    // Index base+off folded into 0..N_IN-1; base < N_IN and off <= N_IN,
    // so a single conditional subtraction is enough (N_IN need not be 2^k).
    function automatic logic [GNT_W-1:0] f_wrap_add(input logic [GNT_W-1:0] base,
                                                   input int               off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_IN) begin
            sum = sum - N_IN;
        end
        return GNT_W'(sum);
    endfunction

    assign w_lock      = (r_state == ST_LOCK);
    assign w_hs        = w_lock && s_valid[r_grant] && m_ready;
    assign w_last_beat = (r_beat_cnt == CNT_W'(N_BEATS - 1));

    // Round-robin pick: scan from farthest to nearest so the nearest
    // requester after last_grant is the one left standing.
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = '0;
        for (int k = N_IN; k >= 1; k--) begin
            if (s_valid[f_wrap_add(r_last_grant, k)]) begin
                w_any_req = 1'b1;
                w_pick    = f_wrap_add(r_last_grant, k);
            end
        end
    end

    // Zero-latency handshake pass-through for the locked owner only.
    always_comb begin
        w_m_valid = 1'b0;
        w_s_ready = '0;
        if (w_lock) begin
            w_m_valid          = s_valid[r_grant];
            w_s_ready[r_grant] = m_ready;
        end
    end

    // Data path is muxed word by word; idle forces the bus to zero.
    for (genvar gw = 0; gw < WORDS_PER_BEAT; gw++) begin : g_word
        assign w_m_data[gw*WORD_W +: WORD_W] =
            w_lock ? s_data[int'(r_grant)*BUS_W + gw*WORD_W +: WORD_W]
                   : {WORD_W{1'b0}};
    end

    // Packet lock FSM: arbitrate in IDLE, count handshakes in LOCK,
    // release after the last beat so the next grant sees one bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GNT_W'(N_IN - 1);
            r_busy       <= 1'b0;
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant    <= w_pick;
                        r_busy     <= 1'b1;
                        r_beat_cnt <= '0;
                        r_state    <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (w_hs) begin
                        if (w_last_beat) begin
                            r_last_grant <= r_grant;
                            r_busy       <= 1'b0;
                            r_beat_cnt   <= '0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_valid  = w_m_valid;
    assign s_ready  = w_s_ready;
    assign m_data   = w_m_data;
    assign grant    = r_grant;
    assign busy     = r_busy;
    assign beat_cnt = r_beat_cnt;

endmodule
`default_nettype wire
